viterbi_link_sequencer: RTL and testbench

VITERBI_LINK_SEQUENCER -- requirements
Module: viterbi_link_sequencer

---
 rtl/viterbi_link_sequencer.sv | 175 +++++++++++++++++
 tb/tb_viterbi_link_sequencer.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/viterbi_link_sequencer.sv
// Viterbi link sequencer: sends one LFSR payload frame plus zero tail bits to an
// external encoder, optionally injects channel bit errors, and compares the
// decoder output against a reference LFSR to count residual bit errors.
// Ports:
//   clk, rst           - clock, synchronous active-high reset
//   start_i            - frame request (honoured only in IDLE)
//   err_mode_i         - 00 none, 01 periodic, 10 random, 11 none (captured at start)
//   err_mask_i         - channel bits flipped on an injection (captured at start)
//   dec_bit_i          - decoder output bit
//   enc_bit_o          - encoder data bit
//   enc_enable_o       - encoder enable
//   err_inj_o          - XOR mask for the channel register
//   busy_o, done_o     - frame in progress / one-cycle end-of-frame pulse
//   inj_ct_o           - flipped channel bits in the last or current frame
//   bit_err_ct_o       - decoded-bit mismatches in the last or current frame
module viterbi_link_sequencer #(
  parameter int unsigned FRAME_LEN = 256,
  parameter int unsigned TAIL      = 8,
  parameter int unsigned N         = 3,
  parameter int unsigned DEC_LAT   = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [1:0]  err_mode_i,
  input  logic [1:0]  err_mask_i,
  input  logic        dec_bit_i,
  output logic        enc_bit_o,
  output logic        enc_enable_o,
  output logic [1:0]  err_inj_o,
  output logic        busy_o,
  output logic        done_o,
  output logic [15:0] inj_ct_o,
  output logic [15:0] bit_err_ct_o
);

  localparam int unsigned VW        = DEC_LAT;
  localparam logic [15:0] DATA_SEED = 16'hACE1;
  localparam logic [15:0] ERR_SEED  = 16'h1D0F;

  typedef enum logic [2:0] {S_IDLE, S_SEND, S_TAIL, S_DRAIN, S_DONE} state_t;

  // x^16+x^14+x^13+x^11+1, right-shifting Fibonacci form, output on bit 0
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
  endfunction

  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [1:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {15'd0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  state_t        state, state_d;
  logic [31:0]   cnt, cnt_d;
  logic [15:0]   samp_ct, samp_d;
  logic [1:0]    mode, mode_d, mask, mask_d;
  logic [15:0]   data_lfsr, data_d, ref_lfsr, ref_d, err_lfsr, err_d;
  logic [VW-1:0] vld;
  logic          enc_bit_d, enable_d, busy_d, done_d, inj_hit;
  logic [1:0]    inj_d;
  logic [15:0]   inj_ct_d, err_ct_d;
  logic          sample_c, cmp_done_c;

  // a SEND cycle's decoded bit arrives exactly DEC_LAT cycles later
  assign sample_c   = vld[VW-1];
  assign cmp_done_c = (samp_ct == 16'(FRAME_LEN)) ||
                      (sample_c && (samp_ct == 16'(FRAME_LEN - 1)));

  // next-state, counters and next output values
  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    samp_d   = samp_ct;
    mode_d   = mode;
    mask_d   = mask;
    data_d   = data_lfsr;
    ref_d    = ref_lfsr;
    err_d    = err_lfsr;
    inj_ct_d = inj_ct_o;
    err_ct_d = bit_err_ct_o;
    inj_hit  = 1'b0;

    // compare runs independently of the state so samples on transitions are kept
    if (sample_c) begin
      ref_d  = lfsr_step(ref_lfsr);
      samp_d = samp_ct + 16'd1;
      if (dec_bit_i != ref_lfsr[0]) err_ct_d = sat_add(bit_err_ct_o, 2'd1);
    end
    inj_ct_d = sat_add(inj_ct_o, {1'b0, err_inj_o[0]} + {1'b0, err_inj_o[1]});

    unique case (state)
      S_IDLE: begin
        if (start_i) begin
          state_d  = S_SEND;
          cnt_d    = 32'd0;
          samp_d   = 16'd0;
          mode_d   = err_mode_i;
          mask_d   = err_mask_i;
          data_d   = DATA_SEED;
          ref_d    = DATA_SEED;
          err_d    = ERR_SEED;
          inj_ct_d = 16'd0;
          err_ct_d = 16'd0;
        end
      end
      S_SEND: begin
        data_d = lfsr_step(data_lfsr);
        err_d  = lfsr_step(err_lfsr);
        if (cnt == 32'(FRAME_LEN - 1)) begin
          state_d = S_TAIL;
          cnt_d   = 32'd0;
        end else begin
          cnt_d = cnt + 32'd1;
        end
      end
      S_TAIL: begin
        if (cnt == 32'(TAIL - 1)) state_d = cmp_done_c ? S_DONE : S_DRAIN;
        else                      cnt_d   = cnt + 32'd1;
      end
      S_DRAIN: if (cmp_done_c) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // outputs are registered, so they are derived from the next state
    if (mode_d == 2'b01)      inj_hit = &cnt_d[N-1:0];
    else if (mode_d == 2'b10) inj_hit = (err_d[N-1:0] == '0);
    enable_d  = (state_d == S_SEND) || (state_d == S_TAIL);
    enc_bit_d = (state_d == S_SEND) && data_d[0];
    inj_d     = ((state_d == S_SEND) && inj_hit) ? mask_d : 2'b00;
    busy_d    = (state_d != S_IDLE);
    done_d    = (state_d == S_DONE);
  end

  // state, datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      cnt          <= 32'd0;
      samp_ct      <= 16'd0;
      mode         <= 2'b00;
      mask         <= 2'b00;
      data_lfsr    <= DATA_SEED;
      ref_lfsr     <= DATA_SEED;
      err_lfsr     <= ERR_SEED;
      vld          <= '0;
      enc_bit_o    <= 1'b0;
      enc_enable_o <= 1'b0;
      err_inj_o    <= 2'b00;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      inj_ct_o     <= 16'd0;
      bit_err_ct_o <= 16'd0;
    end else begin
      state        <= state_d;
      cnt          <= cnt_d;
      samp_ct      <= samp_d;
      mode         <= mode_d;
      mask         <= mask_d;
      data_lfsr    <= data_d;
      ref_lfsr     <= ref_d;
      err_lfsr     <= err_d;
      vld          <= VW'({vld, state == S_SEND});
      enc_bit_o    <= enc_bit_d;
      enc_enable_o <= enable_d;
      err_inj_o    <= inj_d;
      busy_o       <= busy_d;
      done_o       <= done_d;
      inj_ct_o     <= inj_ct_d;
      bit_err_ct_o <= err_ct_d;
    end
  end

endmodule

// File: tb/tb_viterbi_link_sequencer.sv
// Directed bench for viterbi_link_sequencer: ideal loopback decoder model,
// per-cycle check of encoder bits and injection masks, frame-level counters.
module tb_viterbi_link_sequencer;

  localparam int FL = 256;
  localparam int DL = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [1:0]  err_mode_i;
  logic [1:0]  err_mask_i;
  logic        dec_bit_i;
  logic        enc_bit_o;
  logic        enc_enable_o;
  logic [1:0]  err_inj_o;
  logic        busy_o;
  logic        done_o;
  logic [15:0] inj_ct_o;
  logic [15:0] bit_err_ct_o;

  viterbi_link_sequencer dut (
    .clk(clk), .rst(rst), .start_i(start_i), .err_mode_i(err_mode_i),
    .err_mask_i(err_mask_i), .dec_bit_i(dec_bit_i), .enc_bit_o(enc_bit_o),
    .enc_enable_o(enc_enable_o), .err_inj_o(err_inj_o), .busy_o(busy_o),
    .done_o(done_o), .inj_ct_o(inj_ct_o), .bit_err_ct_o(bit_err_ct_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // loopback model and frame statistics
  logic        dly [0:DL];
  int          idxp [0:DL];
  int          flip_k, sendn, cur_idx;
  int          busy_cy, done_ct, en_cy, enc_bad, inj_bad, exp_inj_ct;
  logic [1:0]  cur_mode, cur_mask;
  logic [15:0] dl, el;

  function automatic logic [15:0] step16(input logic [15:0] l);
    logic fb;
    fb = l[16-16] ^ l[16-14] ^ l[16-13] ^ l[16-11];
    return (l >> 1) | ({15'd0, fb} << 15);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
  endtask

  // one cycle: observe at the falling edge, update the decoder model and tallies
  task automatic tick();
    logic       exp_bit, hit;
    logic [1:0] exp_inj;
    @(negedge clk);
    cur_idx = (enc_enable_o && sendn < FL) ? sendn : -1;
    for (int i = DL; i > 0; i--) begin
      dly[i]  = dly[i-1];
      idxp[i] = idxp[i-1];
    end
    dly[0]  = enc_bit_o;
    idxp[0] = cur_idx;
    dec_bit_i = dly[DL] ^ ((flip_k >= 0) && (idxp[DL] == flip_k));
    exp_bit = 1'b0;
    exp_inj = 2'b00;
    if (cur_idx >= 0) begin
      exp_bit = dl[0];
      hit = 1'b0;
      if (cur_mode == 2'b01) hit = ((sendn % 8) == 7);
      if (cur_mode == 2'b10) hit = (el[2:0] == 3'b000);
      if (hit) exp_inj = cur_mask;
      dl = step16(dl);
      el = step16(el);
      sendn++;
    end
    if (enc_bit_o !== exp_bit) enc_bad++;
    if (err_inj_o !== exp_inj) inj_bad++;
    exp_inj_ct += int'(exp_inj[0]) + int'(exp_inj[1]);
    busy_cy += int'(busy_o);
    done_ct += int'(done_o);
    en_cy   += int'(enc_enable_o);
  endtask

  // run one frame; poke re-pulses start during SEND and DONE; abort_at asserts rst
  task automatic run_frame(input string name, input logic [1:0] mode, input logic [1:0] mask,
                           input int flip, input bit poke, input int abort_at,
                           input int exp_inj, input int exp_err);
    int cyc;
    bit fin;
    err_mode_i = mode;
    err_mask_i = mask;
    flip_k     = flip;
    cur_mode   = (mode == 2'b11) ? 2'b00 : mode;
    cur_mask   = mask;
    sendn = 0; dl = 16'hACE1; el = 16'h1D0F;
    busy_cy = 0; done_ct = 0; en_cy = 0; enc_bad = 0; inj_bad = 0; exp_inj_ct = 0;
    start_i = 1'b1;
    cyc = 0;
    fin = 1'b0;
    while (!fin && cyc < 2000) begin
      tick();
      cyc++;
      start_i = poke && (cur_idx == 20 || done_o);
      if (done_o) fin = 1'b1;
      if (abort_at >= 0 && cur_idx == abort_at) begin
        rst = 1'b1;
        fin = 1'b1;
      end
    end
    check({name, " finished in time"}, 32'(fin), 32'd1);
    if (abort_at < 0) begin
      tick();
      start_i = 1'b0;
      check({name, " done pulses"}, 32'(done_ct), 32'd1);
      check({name, " busy cycles"}, 32'(busy_cy), 32'(FL + 8 + 24 + 1));
      check({name, " enable cycles"}, 32'(en_cy), 32'(FL + 8));
      check({name, " enc bit errors"}, 32'(enc_bad), 32'd0);
      check({name, " inject pattern errors"}, 32'(inj_bad), 32'd0);
      check({name, " inj_ct vs model"}, 32'(inj_ct_o), 32'(exp_inj_ct));
      if (exp_inj >= 0) check({name, " inj_ct"}, 32'(inj_ct_o), 32'(exp_inj));
      check({name, " bit_err_ct"}, 32'(bit_err_ct_o), 32'(exp_err));
      check({name, " idle busy"}, 32'(busy_o), 32'd0);
      check({name, " idle done"}, 32'(done_o), 32'd0);
    end
  endtask

  initial begin
    for (int i = 0; i <= DL; i++) begin
      dly[i]  = 1'b0;
      idxp[i] = -1;
    end
    rst = 1'b1; start_i = 1'b0; err_mode_i = 2'b00; err_mask_i = 2'b00; dec_bit_i = 1'b0;
    flip_k = -1; sendn = FL; cur_mode = 2'b00; cur_mask = 2'b00; dl = 16'hACE1; el = 16'h1D0F;
    tick();
    tick();
    check("reset enc_bit", 32'(enc_bit_o), 32'd0);
    check("reset enc_enable", 32'(enc_enable_o), 32'd0);
    check("reset err_inj", 32'(err_inj_o), 32'd0);
    check("reset busy", 32'(busy_o), 32'd0);
    check("reset done", 32'(done_o), 32'd0);
    check("reset inj_ct", 32'(inj_ct_o), 32'd0);
    check("reset bit_err_ct", 32'(bit_err_ct_o), 32'd0);
    rst = 1'b0;
    tick();

    run_frame("clean",      2'b00, 2'b00, -1,  1'b0, -1, 0,  0);
    run_frame("periodic10", 2'b01, 2'b10, -1,  1'b0, -1, 32, 0);
    run_frame("periodic11", 2'b01, 2'b11, -1,  1'b0, -1, 64, 0);
    run_frame("random01",   2'b10, 2'b01, -1,  1'b0, -1, -1, 0);
    run_frame("mode11",     2'b11, 2'b11, -1,  1'b0, -1, 0,  0);
    run_frame("flip100",    2'b00, 2'b00, 100, 1'b0, -1, 0,  1);

    // start pulses mid-frame and in DONE must not restart or disturb counters
    run_frame("poke", 2'b01, 2'b10, -1, 1'b1, -1, 32, 0);
    for (int i = 0; i < 5; i++) tick();
    check("poke stays idle", 32'(busy_o), 32'd0);
    check("poke no extra done", 32'(done_ct), 32'd1);
    check("poke inj_ct held", 32'(inj_ct_o), 32'd32);
    check("poke bit_err_ct held", 32'(bit_err_ct_o), 32'd0);

    // reset in the middle of SEND
    run_frame("abort", 2'b01, 2'b11, -1, 1'b0, 50, -1, 0);
    tick();
    check("abort enc_bit", 32'(enc_bit_o), 32'd0);
    check("abort enc_enable", 32'(enc_enable_o), 32'd0);
    check("abort err_inj", 32'(err_inj_o), 32'd0);
    check("abort busy", 32'(busy_o), 32'd0);
    check("abort done", 32'(done_o), 32'd0);
    check("abort inj_ct", 32'(inj_ct_o), 32'd0);
    check("abort bit_err_ct", 32'(bit_err_ct_o), 32'd0);
    rst = 1'b0;
    tick();
    run_frame("after abort", 2'b00, 2'b00, -1, 1'b0, -1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
